// File: rtl/axi_rd_pkg.sv
// Shared definitions for the AXI read-request scheduler: burst and response
// encodings, scheduler state encoding, default sideband constants and a
// round-robin pointer helper.
`timescale 1ns/1ps
package axi_rd_pkg;

    // AXI burst type encodings
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;

    // AXI read response codes
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Sideband fields that are never varied by this master
    localparam logic [1:0] LOCK_DEFAULT  = 2'b00;
    localparam logic [1:0] CACHE_DEFAULT = 2'b00;
    localparam logic [2:0] PROT_DEFAULT  = 3'b000;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } sched_state_t;

    // Next round-robin start position after serving requester idx (mod n)
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches the request vector starting at
// ptr and wrapping at N; returns a one-hot grant and its encoded index.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx
);
    localparam int PW  = $clog2(N);
    localparam int PW1 = PW + 1;

    logic [PW1-1:0] w_pos;
    logic           w_found;

    // First requester at or after the pointer wins; later hits are ignored
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, i_ptr} + PW1'(k);
            if (w_pos >= PW1'(N)) begin
                w_pos = w_pos - PW1'(N);
            end
            if (!w_found && i_req[w_pos[PW-1:0]]) begin
                w_found                = 1'b1;
                o_grant[w_pos[PW-1:0]] = 1'b1;
                o_idx                  = w_pos[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/axi_rd_req_scheduler.sv
// Shares one AXI read controller between NUM_REQ requesters. One transaction
// at a time: round-robin grant, latched request fields with a one-cycle start
// pulse, zero-latency routing of returned beats to the owner, and a watchdog
// that aborts a transaction whose slave stops returning beats.
`timescale 1ns/1ps
module axi_rd_req_scheduler
    import axi_rd_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int data_width = 64,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          AClk,
    input  logic                          ARst,
    // requester side
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*addr_width-1:0] req_addr,
    input  logic [NUM_REQ*4-1:0]          req_len,
    input  logic [NUM_REQ*3-1:0]          req_size,
    input  logic [NUM_REQ*2-1:0]          req_burst,
    // read controller request side
    output logic [addr_width-1:0]         araddr_d,
    output logic [3:0]                    TXN_ID_R_d,
    output logic [3:0]                    arlen_d,
    output logic [2:0]                    arsize_d,
    output logic [1:0]                    arburst_d,
    output logic [1:0]                    arlock_d,
    output logic [1:0]                    arcache_d,
    output logic [2:0]                    arprot_d,
    output logic                          rd_trn_en,
    // read controller response side
    input  logic [data_width-1:0]         rdata_d,
    input  logic [1:0]                    rresp_d,
    input  logic [3:0]                    rid_d,
    input  logic                          rd_rsp_en_d,
    input  logic                          r_last_d,
    // requester response side
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [data_width-1:0]         rsp_data,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_last,
    output logic                          id_err,
    output logic                          timeout_err
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT) + 1;

    sched_state_t            r_state;
    sched_state_t            w_state_next;

    logic [PW-1:0]           r_rr_ptr;
    logic [PW-1:0]           r_owner;
    logic [addr_width-1:0]   r_addr;
    logic [3:0]              r_len;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic [WW-1:0]           r_wd;

    logic [NUM_REQ-1:0]      w_grant;
    logic [PW-1:0]           w_grant_idx;
    logic                    w_any_req;
    logic [NUM_REQ-1:0]      w_owner_oh;
    logic                    w_in_wait;
    logic                    w_beat;
    logic                    w_done;
    logic                    w_timeout;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx)
    );

    // One-hot decode of the current owner for response steering
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner_oh
        assign w_owner_oh[gi] = (r_owner == PW'(gi));
    end

    assign w_any_req = |req_valid;
    assign w_in_wait = (r_state == ST_WAIT);
    assign w_beat    = w_in_wait & rd_rsp_en_d;
    // r_last_d alone (no beat) still closes the transaction
    assign w_done    = w_in_wait & r_last_d;
    // A beat or a completion in the expiry cycle takes precedence
    assign w_timeout = w_in_wait & ~rd_rsp_en_d & ~r_last_d &
                       (r_wd == WW'(TIMEOUT - 1));

    // Request fields seen by the controller stay at their last latched values
    assign araddr_d   = r_addr;
    assign TXN_ID_R_d = 4'(r_owner);
    assign arlen_d    = r_len;
    assign arsize_d   = r_size;
    assign arburst_d  = r_burst;
    assign arlock_d   = LOCK_DEFAULT;
    assign arcache_d  = CACHE_DEFAULT;
    assign arprot_d   = PROT_DEFAULT;

    // FSM state register
    always_ff @(posedge AClk) begin
        if (!ARst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and all per-cycle handshake/response outputs
    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        rd_trn_en    = 1'b0;
        rsp_valid    = '0;
        rsp_data     = rdata_d;
        rsp_resp     = rresp_d;
        rsp_last     = 1'b0;
        id_err       = 1'b0;
        timeout_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Requesters hold valid until ready, so an empty vector here
                // only happens on a protocol violation; fall back to idle.
                if (w_any_req) begin
                    req_ready    = w_grant;
                    w_state_next = ST_ISSUE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                rd_trn_en    = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_timeout) begin
                    rsp_valid    = w_owner_oh;
                    rsp_data     = '0;
                    rsp_resp     = SLVERR;
                    rsp_last     = 1'b1;
                    timeout_err  = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    rsp_valid = w_owner_oh & {NUM_REQ{rd_rsp_en_d}};
                    rsp_last  = rd_rsp_en_d & r_last_d;
                    id_err    = rd_rsp_en_d & (rid_d != 4'(r_owner));
                    if (w_done) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the winner's request fields and index when it is granted
    always_ff @(posedge AClk) begin
        if (!ARst) begin
            r_owner <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else if ((r_state == ST_GRANT) && w_any_req) begin
            r_owner <= w_grant_idx;
            r_addr  <= req_addr[w_grant_idx*addr_width +: addr_width];
            r_len   <= req_len[w_grant_idx*4 +: 4];
            r_size  <= req_size[w_grant_idx*3 +: 3];
            r_burst <= req_burst[w_grant_idx*2 +: 2];
        end
    end

    // Move the round-robin start past the owner once its transaction ends
    always_ff @(posedge AClk) begin
        if (!ARst) begin
            r_rr_ptr <= '0;
        end else if (w_done || w_timeout) begin
            r_rr_ptr <= PW'(rr_next(int'(r_owner), NUM_REQ));
        end
    end

    // Watchdog: cycles since issue or since the most recent beat
    always_ff @(posedge AClk) begin
        if (!ARst) begin
            r_wd <= '0;
        end else if ((r_state == ST_ISSUE) || w_beat) begin
            r_wd <= '0;
        end else if (w_in_wait) begin
            r_wd <= r_wd + 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_rd_req_scheduler.sv
// Directed bench for axi_rd_req_scheduler (NUM_REQ=4, TIMEOUT=16): single
// request, round-robin order, busy hold, ID mismatch, watchdog abort, beat vs
// watchdog priority, last-without-beat completion and mid-burst reset.
`timescale 1ns/1ps
module tb_axi_rd_req_scheduler;
    import axi_rd_pkg::*;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int NR = 4;
    localparam int TO = 16;

    logic              AClk = 1'b0;
    logic              ARst = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_addr  = '0;
    logic [NR*4-1:0]   req_len   = '0;
    logic [NR*3-1:0]   req_size  = '0;
    logic [NR*2-1:0]   req_burst = '0;
    logic [AW-1:0]     araddr_d;
    logic [3:0]        TXN_ID_R_d;
    logic [3:0]        arlen_d;
    logic [2:0]        arsize_d;
    logic [1:0]        arburst_d;
    logic [1:0]        arlock_d;
    logic [1:0]        arcache_d;
    logic [2:0]        arprot_d;
    logic              rd_trn_en;
    logic [DW-1:0]     rdata_d = '0;
    logic [1:0]        rresp_d = '0;
    logic [3:0]        rid_d = '0;
    logic              rd_rsp_en_d = 1'b0;
    logic              r_last_d = 1'b0;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [1:0]        rsp_resp;
    logic              rsp_last;
    logic              id_err;
    logic              timeout_err;

    int n_total = 0;
    int n_bad   = 0;

    logic [AW-1:0] e_addr  [NR];
    logic [3:0]    e_len   [NR];
    logic [2:0]    e_size  [NR];
    logic [1:0]    e_burst [NR];

    axi_rd_req_scheduler #(
        .addr_width (AW),
        .data_width (DW),
        .NUM_REQ    (NR),
        .TIMEOUT    (TO)
    ) dut (
        .AClk        (AClk),
        .ARst        (ARst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_size    (req_size),
        .req_burst   (req_burst),
        .araddr_d    (araddr_d),
        .TXN_ID_R_d  (TXN_ID_R_d),
        .arlen_d     (arlen_d),
        .arsize_d    (arsize_d),
        .arburst_d   (arburst_d),
        .arlock_d    (arlock_d),
        .arcache_d   (arcache_d),
        .arprot_d    (arprot_d),
        .rd_trn_en   (rd_trn_en),
        .rdata_d     (rdata_d),
        .rresp_d     (rresp_d),
        .rid_d       (rid_d),
        .rd_rsp_en_d (rd_rsp_en_d),
        .r_last_d    (r_last_d),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_resp    (rsp_resp),
        .rsp_last    (rsp_last),
        .id_err      (id_err),
        .timeout_err (timeout_err)
    );

    always #5 AClk = ~AClk;

    initial begin
        #100000;
        $display("FAIL global_time_limit: got running want finished");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge AClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [3:0] l,
                            input logic [2:0] s, input logic [1:0] b);
        req_addr[i*AW +: AW] = a;
        req_len[i*4 +: 4]    = l;
        req_size[i*3 +: 3]   = s;
        req_burst[i*2 +: 2]  = b;
        e_addr[i]  = a;
        e_len[i]   = l;
        e_size[i]  = s;
        e_burst[i] = b;
    endtask

    // Starts in an IDLE cycle with req_valid already driven; ends in WAIT cycle 1
    task automatic grant_cycle(input int owner, input logic [NR-1:0] next_valid);
        logic [NR-1:0] oh;
        oh = 4'b0001 << owner;
        #1;
        chk("idle_ready", 64'(req_ready), 64'h0);
        tick();
        chk("grant_ready", 64'(req_ready), 64'(oh));
        chk("grant_trn_en", 64'(rd_trn_en), 64'h0);
        tick();
        req_valid = next_valid;
        #1;
        chk("issue_trn_en", 64'(rd_trn_en), 64'h1);
        chk("issue_ready", 64'(req_ready), 64'h0);
        chk("issue_id", 64'(TXN_ID_R_d), 64'(owner));
        chk("issue_addr", 64'(araddr_d), 64'(e_addr[owner]));
        chk("issue_len", 64'(arlen_d), 64'(e_len[owner]));
        chk("issue_size", 64'(arsize_d), 64'(e_size[owner]));
        chk("issue_burst", 64'(arburst_d), 64'(e_burst[owner]));
        chk("issue_sideband", 64'({arlock_d, arcache_d, arprot_d}), 64'h0);
        tick();
        chk("wait_trn_en", 64'(rd_trn_en), 64'h0);
        chk("wait_addr_hold", 64'(araddr_d), 64'(e_addr[owner]));
        $display("grant owner=%0d addr=%0h len=%0d", owner, araddr_d, arlen_d);
    endtask

    // n beats in WAIT, last one flagged; rid may differ from the owner
    task automatic beats(input int owner, input int n, input logic [3:0] rid);
        logic [NR-1:0] oh;
        logic [DW-1:0] d;
        oh = 4'b0001 << owner;
        for (int b = 0; b < n; b++) begin
            d = 64'hA5A5_0000_0000_0000 + 64'(owner * 256 + b);
            rdata_d     = d;
            rresp_d     = (b == 1) ? 2'b01 : OKAY;
            rid_d       = rid;
            rd_rsp_en_d = 1'b1;
            r_last_d    = (b == n - 1);
            #1;
            chk("beat_valid", 64'(rsp_valid), 64'(oh));
            chk("beat_data", rsp_data, d);
            chk("beat_resp", 64'(rsp_resp), (b == 1) ? 64'h1 : 64'h0);
            chk("beat_last", 64'(rsp_last), (b == n - 1) ? 64'h1 : 64'h0);
            chk("beat_id_err", 64'(id_err), (rid != 4'(owner)) ? 64'h1 : 64'h0);
            chk("beat_ready", 64'(req_ready), 64'h0);
            chk("beat_tmo", 64'(timeout_err), 64'h0);
            tick();
        end
        rd_rsp_en_d = 1'b0;
        r_last_d    = 1'b0;
        rid_d       = '0;
        rdata_d     = '0;
        rresp_d     = OKAY;
        $display("beats owner=%0d n=%0d rid=%0d", owner, n, rid);
    endtask

    task automatic do_reset();
        ARst      = 1'b0;
        req_valid = '0;
        tick();
        ARst = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_trn_en", 64'(rd_trn_en), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_last", 64'(rsp_last), 64'h0);
        chk("rst_id_err", 64'(id_err), 64'h0);
        chk("rst_tmo", 64'(timeout_err), 64'h0);
        chk("rst_txn_id", 64'(TXN_ID_R_d), 64'h0);
        chk("rst_addr", 64'(araddr_d), 64'h0);
        chk("rst_len", 64'(arlen_d), 64'h0);
        ARst = 1'b1;
        tick();

        // Single request from requester 2
        set_slot(2, 32'h0000_1000, 4'd3, 3'd3, INCR);
        req_valid = 4'b0100;
        grant_cycle(2, 4'b0000);
        beats(2, 4, 4'd2);
        #1;
        chk("t1_idle_valid", 64'(rsp_valid), 64'h0);
        chk("t1_field_hold", 64'(araddr_d), 64'h1000);

        // All four valid from reset: order 0,1,2,3,0
        do_reset();
        set_slot(0, 32'h0000_2000, 4'd0, 3'd0, FIXED);
        set_slot(1, 32'h0000_2040, 4'd1, 3'd1, INCR);
        set_slot(2, 32'h0000_2080, 4'd2, 3'd2, WRAP);
        set_slot(3, 32'h0000_20C0, 4'd7, 3'd3, INCR);
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            grant_cycle(g % 4, 4'b1111);
            beats(g % 4, 1, 4'(g % 4));
        end
        req_valid = 4'b0000;

        // Busy hold: requester 1 waits through requester 0's 8-beat burst
        req_valid = 4'b0001;
        grant_cycle(0, 4'b0000);
        req_valid = 4'b0010;
        beats(0, 8, 4'd0);
        grant_cycle(1, 4'b0000);
        beats(1, 1, 4'd1);

        // ID mismatch: owner 3, slave answers with ID 5
        req_valid = 4'b1000;
        grant_cycle(3, 4'b0000);
        beats(3, 2, 4'd5);
        #1;
        chk("t4_id_err_clear", 64'(id_err), 64'h0);

        // Watchdog abort with no beats
        req_valid = 4'b0100;
        grant_cycle(2, 4'b0000);
        rdata_d = 64'hFFFF_FFFF_FFFF_FFFF;
        rresp_d = 2'b01;
        for (int k = 1; k < TO; k++) begin
            #1;
            chk("wd_quiet_tmo", 64'(timeout_err), 64'h0);
            chk("wd_quiet_valid", 64'(rsp_valid), 64'h0);
            tick();
        end
        #1;
        chk("wd_valid", 64'(rsp_valid), 64'h4);
        chk("wd_resp", 64'(rsp_resp), 64'(SLVERR));
        chk("wd_last", 64'(rsp_last), 64'h1);
        chk("wd_data", rsp_data, 64'h0);
        chk("wd_tmo", 64'(timeout_err), 64'h1);
        tick();
        rdata_d = '0;
        rresp_d = OKAY;
        #1;
        chk("wd_after_tmo", 64'(timeout_err), 64'h0);
        $display("watchdog abort owner=2");

        // Next grant proceeds (pointer now 3, wraps to 0); beat beats watchdog
        req_valid = 4'b0011;
        grant_cycle(0, 4'b0010);
        for (int k = 1; k < TO; k++) begin
            tick();
        end
        rd_rsp_en_d = 1'b1;
        rid_d       = 4'd0;
        rdata_d     = 64'h1234;
        #1;
        chk("race_tmo", 64'(timeout_err), 64'h0);
        chk("race_valid", 64'(rsp_valid), 64'h1);
        chk("race_resp", 64'(rsp_resp), 64'(OKAY));
        chk("race_last", 64'(rsp_last), 64'h0);
        tick();
        rd_rsp_en_d = 1'b0;
        rdata_d     = '0;
        tick();
        tick();
        // Last flag without a beat completes silently
        r_last_d = 1'b1;
        #1;
        chk("lastonly_valid", 64'(rsp_valid), 64'h0);
        chk("lastonly_last", 64'(rsp_last), 64'h0);
        chk("lastonly_tmo", 64'(timeout_err), 64'h0);
        tick();
        r_last_d = 1'b0;
        $display("beat-vs-watchdog and last-only completion owner=0");
        grant_cycle(1, 4'b0000);

        // Reset mid-burst after beat 2 of 4
        for (int b = 0; b < 2; b++) begin
            rd_rsp_en_d = 1'b1;
            rid_d       = 4'd1;
            rdata_d     = 64'(b + 1);
            #1;
            chk("mid_beat_valid", 64'(rsp_valid), 64'h2);
            tick();
        end
        ARst = 1'b0;
        tick();
        chk("mr_ready", 64'(req_ready), 64'h0);
        chk("mr_trn_en", 64'(rd_trn_en), 64'h0);
        chk("mr_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("mr_rsp_last", 64'(rsp_last), 64'h0);
        chk("mr_id_err", 64'(id_err), 64'h0);
        chk("mr_tmo", 64'(timeout_err), 64'h0);
        chk("mr_txn_id", 64'(TXN_ID_R_d), 64'h0);
        chk("mr_addr", 64'(araddr_d), 64'h0);
        rd_rsp_en_d = 1'b0;
        rid_d       = '0;
        rdata_d     = '0;
        ARst        = 1'b1;
        req_valid   = 4'b1111;
        // Pointer back at 0: requester 0 wins
        grant_cycle(0, 4'b0000);
        beats(0, 1, 4'd0);
        $display("reset mid-burst recovered");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
